// File: rtl/srff_seq_pkg.sv
// Shared types and elaboration checks for the SR-flop init sequencer.
//   state_e   : controller FSM states.
//   cfg_legal : true when the timing parameters are usable (both widths >= 1
//               and the timer is wide enough to hold the larger of the two).
package srff_seq_pkg;

  typedef enum logic [2:0] {
    StPorHold,
    StPorRec,
    StIdle,
    StGate,
    StAssert,
    StRecover
  } state_e;

  function automatic bit cfg_legal(int unsigned pw_cyc, int unsigned rec_cyc,
                                   int unsigned cnt_w);
    logic [63:0] cap;
    if (cnt_w == 0 || cnt_w > 32) return 1'b0;
    cap = (64'd1 << cnt_w) - 64'd1;
    return (pw_cyc >= 1) && (rec_cyc >= 1) &&
           (64'(pw_cyc) <= cap) && (64'(rec_cyc) <= cap);
  endfunction

endpackage

// File: rtl/srff_seq_strobe_gen.sv
// Registered per-bit RSTB/SETB strobe generator for the flop bank.
//   clk_i, rst_i : clock, asynchronous active-high reset (forces rstb=0, setb=1)
//   fire_i       : drive strobes from pattern_i/mask_i on the next edge
//   release_i    : return every strobe to 1 on the next edge (wins over fire_i)
//   pattern_i    : target value per bit (1 -> pulse SETB, 0 -> pulse RSTB)
//   mask_i       : 1 = strobe this bit, 0 = keep both strobes high
//   rstb_o/setb_o: active-low async reset/set strobes, both registered
// A bit can only go low on one strobe: masked bits are forced high on both,
// and unmasked bits drive complementary values.
module srff_seq_strobe_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fire_i,
  input  logic             release_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic [WIDTH-1:0] rstb_o,
  output logic [WIDTH-1:0] setb_o
);

  logic [WIDTH-1:0] rstb_d, rstb_q;
  logic [WIDTH-1:0] setb_d, setb_q;

  always_comb begin
    rstb_d = rstb_q;
    setb_d = setb_q;
    if (release_i) begin
      rstb_d = '1;
      setb_d = '1;
    end else if (fire_i) begin
      rstb_d = ~mask_i | pattern_i;
      setb_d = ~mask_i | ~pattern_i;
    end
  end

  // Both strobes change in the same reset event, so the pair is never low together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rstb_q <= '0;
      setb_q <= '1;
    end else begin
      rstb_q <= rstb_d;
      setb_q <= setb_d;
    end
  end

  assign rstb_o = rstb_q;
  assign setb_o = setb_q;

  a_never_both_low : assert property (@(posedge clk_i) ((rstb_q | setb_q) == '1));

endmodule

// File: rtl/srff_init_sequencer.sv
// Sequences the async set/reset pins of a bank of negedge SR flops.
//   CLK, RST : clock (posedge logic), asynchronous active-high reset
//   START    : request an init sequence (accepted only in IDLE)
//   PATTERN  : per-bit target value, latched with START
//   MASK     : per-bit enable, latched with START
//   RSTB_O   : active-low reset strobes
//   SETB_O   : active-low set strobes
//   CLK_EN   : bank clock-gate enable
//   BUSY     : high whenever not in IDLE
//   DONE     : one-cycle pulse at the end of a START-initiated sequence
// All outputs are registered.
module srff_init_sequencer
  import srff_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PW_CYC  = 2,
  parameter int unsigned REC_CYC = 3,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [WIDTH-1:0] MASK,
  output logic [WIDTH-1:0] RSTB_O,
  output logic [WIDTH-1:0] SETB_O,
  output logic             CLK_EN,
  output logic             BUSY,
  output logic             DONE
);

  if (!cfg_legal(PW_CYC, REC_CYC, CNT_W)) begin : g_bad_cfg
    $error("srff_init_sequencer: need PW_CYC>=1, REC_CYC>=1, CNT_W holding both");
  end

  // Timed states are entered with (duration - 1) and leave when the timer is 0.
  localparam logic [CNT_W-1:0] PwLoad  = CNT_W'(PW_CYC - 1);
  localparam logic [CNT_W-1:0] RecLoad = CNT_W'(REC_CYC - 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] timer_d, timer_q;
  logic [CNT_W-1:0] timer_dec;
  logic [WIDTH-1:0] pattern_d, pattern_q;
  logic [WIDTH-1:0] mask_d, mask_q;
  logic             clk_en_d, clk_en_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             fire, release_all;

  assign timer_dec = (timer_q == '0) ? '0 : timer_q - CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_dec;
    pattern_d   = pattern_q;
    mask_d      = mask_q;
    clk_en_d    = clk_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fire        = 1'b0;
    release_all = 1'b0;

    case (state_q)
      // Reset leaves the timer at 0 and it cannot be preloaded, so this one
      // state counts up to the last hold edge instead of down.
      StPorHold: begin
        if (timer_q >= PwLoad) begin
          release_all = 1'b1;
          state_d     = StPorRec;
          timer_d     = RecLoad;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StPorRec: begin
        if (timer_q == '0) begin
          clk_en_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end
      end
      StIdle: begin
        timer_d = '0;
        if (START) begin
          pattern_d = PATTERN;
          mask_d    = MASK;
          clk_en_d  = 1'b0;
          busy_d    = 1'b1;
          // Empty mask skips the strobe phase; timer 0 makes RECOVER expire next edge.
          state_d   = (MASK != '0) ? StGate : StRecover;
        end
      end
      StGate: begin
        fire    = 1'b1;
        state_d = StAssert;
        timer_d = PwLoad;
      end
      StAssert: begin
        if (timer_q == '0) begin
          release_all = 1'b1;
          state_d     = StRecover;
          timer_d     = RecLoad;
        end
      end
      StRecover: begin
        if (timer_q == '0) begin
          clk_en_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: begin
        release_all = 1'b1;
        clk_en_d    = 1'b0;
        busy_d      = 1'b1;
        state_d     = StPorHold;
        timer_d     = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StPorHold;
      timer_q   <= '0;
      pattern_q <= '0;
      mask_q    <= '0;
      clk_en_q  <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      clk_en_q  <= clk_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  srff_seq_strobe_gen #(
    .WIDTH(WIDTH)
  ) u_strobe_gen (
    .clk_i    (CLK),
    .rst_i    (RST),
    .fire_i   (fire),
    .release_i(release_all),
    .pattern_i(pattern_q),
    .mask_i   (mask_q),
    .rstb_o   (RSTB_O),
    .setb_o   (SETB_O)
  );

  assign CLK_EN = clk_en_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_srff_init_sequencer.sv
// Directed bench for srff_init_sequencer at default parameters
// (WIDTH=8, PW_CYC=2, REC_CYC=3). Outputs are sampled 1 time unit after posedge.
module tb_srff_init_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START = 1'b0;
  logic [7:0] PATTERN = 8'h00;
  logic [7:0] MASK = 8'h00;
  logic [7:0] RSTB_O, SETB_O;
  logic       CLK_EN, BUSY, DONE;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  srff_init_sequencer #(
    .WIDTH(8),
    .PW_CYC(2),
    .REC_CYC(3),
    .CNT_W(4)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .PATTERN(PATTERN),
    .MASK   (MASK),
    .RSTB_O (RSTB_O),
    .SETB_O (SETB_O),
    .CLK_EN (CLK_EN),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Invariant on every cycle, plus a DONE pulse counter.
  always @(negedge CLK) begin
    check_eq("never_both_low", RSTB_O | SETB_O, 8'hFF);
    if (DONE === 1'b1) done_cnt++;
  end

  task automatic chk_outs(input string tag, input logic [7:0] r, input logic [7:0] s,
                          input logic ce, input logic bz, input logic dn);
    check_eq({tag, ".rstb"}, RSTB_O, r);
    check_eq({tag, ".setb"}, SETB_O, s);
    check_eq({tag, ".clk_en"}, 8'(CLK_EN), 8'(ce));
    check_eq({tag, ".busy"}, 8'(BUSY), 8'(bz));
    check_eq({tag, ".done"}, 8'(DONE), 8'(dn));
  endtask

  // Assert RST (asynchronously), hold 3 edges, release and follow POR timing.
  task automatic por_seq(input string tag);
    RST = 1'b1;
    #1;
    chk_outs({tag, ".in_rst"}, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    RST = 1'b0;
    tick();  // edge 1 after release
    chk_outs({tag, ".e1"}, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();  // edge 2: reset strobes released
    chk_outs({tag, ".e2"}, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();
    tick();  // edge 4: still recovering
    chk_outs({tag, ".e4"}, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();  // edge 5: clock enabled, no DONE
    chk_outs({tag, ".e5"}, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
  endtask

  // Full sequence; poke=1 issues a conflicting START during the strobe phase.
  task automatic init_seq(input string tag, input logic [7:0] pat, input logic [7:0] msk,
                          input logic [7:0] exp_r, input logic [7:0] exp_s,
                          input logic poke);
    int d0;
    d0 = done_cnt;
    START = 1'b1; PATTERN = pat; MASK = msk;
    tick();  // t0
    START = 1'b0; PATTERN = ~pat; MASK = 8'hFF;
    chk_outs({tag, ".t0"}, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();  // t1
    chk_outs({tag, ".t1"}, exp_r, exp_s, 1'b0, 1'b1, 1'b0);
    if (poke) begin
      START = 1'b1; PATTERN = 8'h3C; MASK = 8'hFF;
    end
    tick();  // t2
    START = 1'b0;
    chk_outs({tag, ".t2"}, exp_r, exp_s, 1'b0, 1'b1, 1'b0);
    tick();  // t3
    chk_outs({tag, ".t3"}, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();
    tick();  // t5
    chk_outs({tag, ".t5"}, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();  // t6
    chk_outs({tag, ".t6"}, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    tick();  // t7
    chk_outs({tag, ".t7"}, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_eq({tag, ".done_count"}, 8'(done_cnt - d0), 8'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #2;
    por_seq("por");
    check_eq("por.no_done", 8'(done_cnt), 8'd0);

    init_seq("basic", 8'hA5, 8'hFF, 8'hA5, 8'h5A, 1'b0);
    init_seq("partial", 8'h0F, 8'h3C, 8'hCF, 8'hF3, 1'b0);
    init_seq("busy_start", 8'hA5, 8'hFF, 8'hA5, 8'h5A, 1'b1);

    // Empty mask: one busy cycle, DONE at t1.
    d0 = done_cnt;
    START = 1'b1; PATTERN = 8'hA5; MASK = 8'h00;
    tick();
    START = 1'b0;
    chk_outs("empty.t0", 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();
    chk_outs("empty.t1", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    tick();
    chk_outs("empty.t2", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_eq("empty.done_count", 8'(done_cnt - d0), 8'd1);

    // START held high re-triggers on the cycle after DONE.
    START = 1'b1; MASK = 8'h00;
    tick();
    check_eq("retrig.t0.busy", 8'(BUSY), 8'd1);
    tick();
    check_eq("retrig.t1.done", 8'(DONE), 8'd1);
    tick();
    START = 1'b0;
    check_eq("retrig.t2.busy", 8'(BUSY), 8'd1);
    check_eq("retrig.t2.done", 8'(DONE), 8'd0);
    tick();
    check_eq("retrig.t3.done", 8'(DONE), 8'd1);
    tick();
    chk_outs("retrig.t4", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of ASSERT (after edge t2).
    d0 = done_cnt;
    START = 1'b1; PATTERN = 8'hA5; MASK = 8'hFF;
    tick();
    START = 1'b0;
    tick();
    tick();
    check_eq("midrst.pre.rstb", RSTB_O, 8'hA5);
    #2;
    por_seq("midrst");
    check_eq("midrst.done_lost", 8'(done_cnt - d0), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
